// File: rtl/mul_div_unit_pkg.sv
// ============================================================================
// Module : mul_div_unit_pkg
// Brief  : MDU op codes, FSM state encodings and small decode helpers.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mul_div_unit_pkg;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // Ops that occupy the unit for multiple cycles
  function automatic logic is_multicycle(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic is_divide(input logic [2:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mul_div_unit.sv
// ============================================================================
// Module : mul_div_unit
// Brief  : Fixed-latency multiply/divide unit owning the HI/LO registers.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Req,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int c_MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int c_CNT_W      = $clog2(c_MAX_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_MUL_CNT = c_CNT_W'(MUL_CYCLES);
  localparam logic [c_CNT_W-1:0] c_DIV_CNT = c_CNT_W'(DIV_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

  logic [0:0]         r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;
  logic [31:0]        r_tmp_hi;
  logic [31:0]        r_tmp_lo;
  logic               r_commit;

  logic               w_accept;
  logic               w_div_zero;
  logic               w_div_ovf;
  logic [31:0]        w_div_s;
  logic [31:0]        w_div_u;
  logic [63:0]        w_prod_s;
  logic [63:0]        w_prod_u;
  logic [31:0]        w_res_hi;
  logic [31:0]        w_res_lo;

  assign w_accept   = Start && !Req && (r_state == ST_IDLE);
  assign w_div_zero = (B == 32'd0);
  // MIN_INT / -1 overflows; dividing by 1 instead yields the required LO=MIN_INT, HI=0
  assign w_div_ovf  = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
  assign w_div_s    = (w_div_zero || w_div_ovf) ? 32'd1 : B;
  assign w_div_u    = w_div_zero ? 32'd1 : B;
  assign w_prod_s   = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign w_prod_u   = {32'd0, A} * {32'd0, B};

  always_comb begin
    w_res_hi = 32'd0;
    w_res_lo = 32'd0;
    case (Op)
      MDU_MULT: begin
        w_res_hi = w_prod_s[63:32];
        w_res_lo = w_prod_s[31:0];
      end
      MDU_MULTU: begin
        w_res_hi = w_prod_u[63:32];
        w_res_lo = w_prod_u[31:0];
      end
      MDU_DIV: begin
        w_res_lo = $signed(A) / $signed(w_div_s);
        w_res_hi = $signed(A) % $signed(w_div_s);
      end
      MDU_DIVU: begin
        w_res_lo = A / w_div_u;
        w_res_hi = A % w_div_u;
      end
      default: begin
        w_res_hi = 32'd0;
        w_res_lo = 32'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_tmp_hi <= 32'd0;
      r_tmp_lo <= 32'd0;
      r_commit <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (is_multicycle(Op)) begin
              r_state  <= ST_BUSY;
              r_cnt    <= is_divide(Op) ? c_DIV_CNT : c_MUL_CNT;
              r_tmp_hi <= w_res_hi;
              r_tmp_lo <= w_res_lo;
              r_commit <= !(is_divide(Op) && w_div_zero);
            end else if (Op == MDU_MTHI) begin
              r_hi <= A;
            end else if (Op == MDU_MTLO) begin
              r_lo <= A;
            end
          end
        end
        ST_BUSY: begin
          if (r_cnt == c_CNT_ONE) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            if (r_commit) begin
              r_hi <= r_tmp_hi;
              r_lo <= r_tmp_lo;
            end
          end else begin
            r_cnt <= r_cnt - c_CNT_ONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign Busy = (r_state == ST_BUSY);
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// ============================================================================
// Module : tb_mul_div_unit
// Brief  : Directed self-checking bench for mul_div_unit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_mul_div_unit;

  logic        clk;
  logic        reset_n;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        Req;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int pass_cnt;
  int total_cnt;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  mul_div_unit #(.MUL_CYCLES(5), .DIV_CYCLES(10)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .Start   (Start),
    .Op      (Op),
    .A       (A),
    .B       (B),
    .Req     (Req),
    .Busy    (Busy),
    .HI      (HI),
    .LO      (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else pass_cnt++;
  endtask

  // Single-cycle pulse of Start with the given op/operands
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1;
    Op    = op;
    A     = a;
    B     = b;
    tick();
    Start = 1'b0;
    Op    = 3'd7;
  endtask

  // Count Busy-high cycles while HI/LO must hold their earlier values
  task automatic wait_busy(input string name, input int exp_cycles,
                           input logic [31:0] hold_hi, input logic [31:0] hold_lo);
    int n;
    logic held;
    n    = 0;
    held = 1'b1;
    while (Busy === 1'b1 && n < 50) begin
      if (HI !== hold_hi || LO !== hold_lo) held = 1'b0;
      tick();
      n++;
    end
    chk({name, "_busy_cycles"}, 32'(n), 32'(exp_cycles));
    chk({name, "_hold"}, {31'd0, held}, 32'd1);
  endtask

  task automatic test_reset();
    issue(OP_MTHI, 32'h1111_2222, 32'd0);
    issue(OP_MTLO, 32'h3333_4444, 32'd0);
    chk("preload_hi", HI, 32'h1111_2222);
    chk("preload_lo", LO, 32'h3333_4444);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("reset_hi", HI, 32'd0);
    chk("reset_lo", LO, 32'd0);
    chk("reset_busy", {31'd0, Busy}, 32'd0);
  endtask

  task automatic test_mult();
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
    chk("mult_busy_start", {31'd0, Busy}, 32'd1);
    wait_busy("mult", 5, 32'd0, 32'd0);
    chk("mult_hi", HI, 32'hFFFF_FFFF);
    chk("mult_lo", LO, 32'hFFFF_FFF1);
    issue(OP_MULTU, 32'hFFFF_FFFD, 32'd5);
    wait_busy("multu", 5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    chk("multu_hi", HI, 32'h0000_0004);
    chk("multu_lo", LO, 32'hFFFF_FFF1);
  endtask

  task automatic test_div();
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_busy("div", 10, 32'h0000_0004, 32'hFFFF_FFF1);
    chk("div_lo", LO, 32'hFFFF_FFFD);
    chk("div_hi", HI, 32'hFFFF_FFFF);
    issue(OP_DIVU, 32'd7, 32'd2);
    wait_busy("divu", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    chk("divu_lo", LO, 32'd3);
    chk("divu_hi", HI, 32'd1);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_busy("div_ovf", 10, 32'd1, 32'd3);
    chk("div_ovf_lo", LO, 32'h8000_0000);
    chk("div_ovf_hi", HI, 32'd0);
  endtask

  task automatic test_div_zero();
    issue(OP_MTLO, 32'h0000_1234, 32'd0);
    issue(OP_MTHI, 32'h0000_5678, 32'd0);
    issue(OP_DIVU, 32'd100, 32'd0);
    wait_busy("divz", 10, 32'h0000_5678, 32'h0000_1234);
    chk("divz_lo", LO, 32'h0000_1234);
    chk("divz_hi", HI, 32'h0000_5678);
  endtask

  task automatic test_req();
    Req = 1'b1;
    issue(OP_MULT, 32'd3, 32'd4);
    Req = 1'b0;
    chk("req_busy", {31'd0, Busy}, 32'd0);
    tick();
    chk("req_hi", HI, 32'h0000_5678);
    chk("req_lo", LO, 32'h0000_1234);
    issue(OP_DIVU, 32'd20, 32'd6);
    Req = 1'b1;
    wait_busy("req_div", 10, 32'h0000_5678, 32'h0000_1234);
    Req = 1'b0;
    chk("req_div_lo", LO, 32'd3);
    chk("req_div_hi", HI, 32'd2);
  endtask

  task automatic test_busy_ignore();
    issue(OP_MULT, 32'd6, 32'd7);
    issue(OP_MTHI, 32'h0000_CAFE, 32'd0);
    issue(OP_MULTU, 32'd9, 32'd9);
    wait_busy("ign", 3, 32'd2, 32'd3);
    chk("ign_hi", HI, 32'd0);
    chk("ign_lo", LO, 32'd42);
    tick();
    chk("ign_idle", {31'd0, Busy}, 32'd0);
  endtask

  task automatic test_reset_mid_op();
    issue(OP_MULT, 32'd10, 32'd10);
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("rmid_busy", {31'd0, Busy}, 32'd0);
    chk("rmid_hi", HI, 32'd0);
    chk("rmid_lo", LO, 32'd0);
    for (int i = 0; i < 8; i++) tick();
    chk("rmid_late_lo", LO, 32'd0);
    chk("rmid_late_busy", {31'd0, Busy}, 32'd0);
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    reset_n   = 1'b0;
    Start     = 1'b0;
    Op        = 3'd7;
    A         = 32'd0;
    B         = 32'd0;
    Req       = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_req();
    test_busy_ignore();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
